// File: rtl/uart_transmitter.sv
// uart_transmitter: serial transmit engine of a 16750-style UART.
// Pops bytes from the TX FIFO and shifts them out on SOUT as a start bit,
// 5-8 data bits (LSB first), an optional parity bit and 1, 1.5 or 2 stop
// bits. Bit timing comes from TXCLK, a one-CLK-wide oversample enable, with
// OVS enables per serial bit.
//
// Build option: define UART_TX_PARITY_EN to build the PARITY state and honour
// PEN/EPS/SP. Without it those three inputs are ignored, DATA goes straight to
// STOP1, and the port list stays the same.
//
// FIFO handshake: FIFO_EMPTY=0 means "valid", and FIFO_Q then holds the head
// byte. FIFO_READ is the "ready/pop" strobe. A byte transfers on a rising CLK
// where FIFO_READ=1. FIFO_READ is raised for exactly one cycle, and only in
// IDLE with FIFO_EMPTY=0, CLEAR=0 and RST=0; the state machine leaves IDLE on
// that same edge, so two pops can never be back to back.
//
// o_dbg_state mirrors the state register
// (0=IDLE 1=START 2=DATA 3=PARITY 4=STOP1 5=STOP2).

module uart_transmitter #(
    parameter int OVS = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TXCLK,
    input  logic       CLEAR,
    input  logic [1:0] WLS,
    input  logic       STB,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       SP,
    input  logic       BC,
    input  logic       FIFO_EMPTY,
    input  logic [7:0] FIFO_Q,
    output logic       FIFO_READ,
    output logic       SOUT,
    output logic       BUSY,
    output logic       TXFINISHED,
    output logic [2:0] o_dbg_state
);

    // The tick counter only has to reach OVS-1.
    localparam int TICK_W = (OVS > 2) ? $clog2(OVS) : 1;
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVS - 1);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVS / 2 - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [TICK_W-1:0] r_tick;
    logic [TICK_W-1:0] w_tick_next;
    logic [TICK_W-1:0] w_tick_last;
    logic [2:0]        r_bit;
    logic [2:0]        w_bit_next;
    logic [2:0]        w_last_bit;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic [1:0]        r_wls;
    logic [1:0]        w_wls_next;
    logic              r_stb;
    logic              w_stb_next;
    logic              r_sout;
    logic              w_sout_next;
    logic              r_busy;
    logic              r_txfinished;
    logic              w_pop;
    logic              w_finish;
    logic              w_bit_end;

`ifdef UART_TX_PARITY_EN
    logic              r_pen;
    logic              w_pen_next;
    logic              r_parity;
    logic              w_parity_next;
    logic              w_parity_calc;
    logic [7:0]        w_data_mask;

    // Parity of the byte being popped, computed only over the bits that will
    // actually be sent; stick parity overrides the computed value.
    always_comb begin
        case (WLS)
            2'b00:   w_data_mask = 8'h1F;
            2'b01:   w_data_mask = 8'h3F;
            2'b10:   w_data_mask = 8'h7F;
            default: w_data_mask = 8'hFF;
        endcase
        if (SP) begin
            w_parity_calc = ~EPS;
        end else if (EPS) begin
            w_parity_calc = ^(FIFO_Q & w_data_mask);
        end else begin
            w_parity_calc = ~(^(FIFO_Q & w_data_mask));
        end
    end
`else
    logic              w_unused_parity;
    assign w_unused_parity = ^{PEN, EPS, SP};
`endif

    // STOP2 is a half bit when 5-bit words ask for two stop bits (1.5 total).
    assign w_tick_last = (r_state == STOP2 && r_wls == 2'b00) ? HALF_LAST : FULL_LAST;
    assign w_bit_end   = TXCLK && (r_tick == w_tick_last);
    assign w_last_bit  = 3'd4 + {1'b0, r_wls};

    // Next-state, counter and shift-register logic; CLEAR overrides it all.
    always_comb begin
        w_state_next  = r_state;
        w_tick_next   = r_tick;
        w_bit_next    = r_bit;
        w_shift_next  = r_shift;
        w_wls_next    = r_wls;
        w_stb_next    = r_stb;
`ifdef UART_TX_PARITY_EN
        w_pen_next    = r_pen;
        w_parity_next = r_parity;
`endif
        w_pop         = 1'b0;
        w_finish      = 1'b0;

        case (r_state)
            IDLE: begin
                if (!FIFO_EMPTY && !CLEAR && !RST) begin
                    w_pop         = 1'b1;
                    w_shift_next  = FIFO_Q;
                    w_tick_next   = '0;
                    w_bit_next    = '0;
                    w_wls_next    = WLS;
                    w_stb_next    = STB;
`ifdef UART_TX_PARITY_EN
                    w_pen_next    = PEN;
                    w_parity_next = w_parity_calc;
`endif
                    w_state_next  = START;
                end
            end
            default: begin
                if (TXCLK) begin
                    if (w_bit_end) begin
                        w_tick_next = '0;
                        case (r_state)
                            START: begin
                                w_bit_next   = '0;
                                w_state_next = DATA;
                            end
                            DATA: begin
                                w_shift_next = {1'b0, r_shift[7:1]};
                                if (r_bit == w_last_bit) begin
                                    w_bit_next = '0;
`ifdef UART_TX_PARITY_EN
                                    w_state_next = r_pen ? PARITY : STOP1;
`else
                                    w_state_next = STOP1;
`endif
                                end else begin
                                    w_bit_next = r_bit + 3'd1;
                                end
                            end
`ifdef UART_TX_PARITY_EN
                            PARITY: begin
                                w_state_next = STOP1;
                            end
`endif
                            STOP1: begin
                                if (r_stb) begin
                                    w_state_next = STOP2;
                                end else begin
                                    w_state_next = IDLE;
                                    w_finish     = 1'b1;
                                end
                            end
                            STOP2: begin
                                w_state_next = IDLE;
                                w_finish     = 1'b1;
                            end
                            default: begin
                                w_state_next = IDLE;
                            end
                        endcase
                    end else begin
                        w_tick_next = r_tick + TICK_W'(1);
                    end
                end
            end
        endcase

        // Abort: drop the character silently, no completion pulse.
        if (CLEAR) begin
            w_state_next = IDLE;
            w_tick_next  = '0;
            w_bit_next   = '0;
            w_finish     = 1'b0;
        end
    end

    // Serial line value for the state being entered; break forces it low.
    always_comb begin
        case (w_state_next)
            START:   w_sout_next = 1'b0;
            DATA:    w_sout_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_sout_next = w_parity_next;
`endif
            default: w_sout_next = 1'b1;
        endcase
        if (BC) begin
            w_sout_next = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counters, character latch and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tick       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_wls        <= '0;
            r_stb        <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_pen        <= 1'b0;
            r_parity     <= 1'b0;
`endif
            r_sout       <= 1'b1;
            r_busy       <= 1'b0;
            r_txfinished <= 1'b0;
        end else begin
            r_tick       <= w_tick_next;
            r_bit        <= w_bit_next;
            r_shift      <= w_shift_next;
            r_wls        <= w_wls_next;
            r_stb        <= w_stb_next;
`ifdef UART_TX_PARITY_EN
            r_pen        <= w_pen_next;
            r_parity     <= w_parity_next;
`endif
            r_sout       <= w_sout_next;
            r_busy       <= (w_state_next != IDLE);
            r_txfinished <= w_finish;
        end
    end

    assign FIFO_READ   = w_pop;
    assign SOUT        = r_sout;
    assign BUSY        = r_busy;
    assign TXFINISHED  = r_txfinished;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed bench for uart_transmitter (OVS=16).
// Cycle numbering: cycle 0 is the cycle in which FIFO_READ is high. Outputs
// are sampled on the falling edge, and inputs change on the falling edge.
// Parity scenarios adapt to whether UART_TX_PARITY_EN is defined.

module tb_uart_transmitter;

    logic       CLK;
    logic       RST;
    logic       TXCLK;
    logic       CLEAR;
    logic [1:0] WLS;
    logic       STB;
    logic       PEN;
    logic       EPS;
    logic       SP;
    logic       BC;
    logic       FIFO_EMPTY;
    logic [7:0] FIFO_Q;
    logic       FIFO_READ;
    logic       SOUT;
    logic       BUSY;
    logic       TXFINISHED;
    logic [2:0] dbg_state;

    int         tests_run;
    int         tests_failed;
    int         pop_count;
    logic [7:0] fifo_model[$];
    logic       sout_log[0:399];
    logic       fin_log[0:399];
    logic       busy_log[0:399];
    logic       read_log[0:399];

    uart_transmitter #(.OVS(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .TXCLK      (TXCLK),
        .CLEAR      (CLEAR),
        .WLS        (WLS),
        .STB        (STB),
        .PEN        (PEN),
        .EPS        (EPS),
        .SP         (SP),
        .BC         (BC),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_Q     (FIFO_Q),
        .FIFO_READ  (FIFO_READ),
        .SOUT       (SOUT),
        .BUSY       (BUSY),
        .TXFINISHED (TXFINISHED),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic fifo_refresh();
        FIFO_EMPTY = (fifo_model.size() == 0);
        FIFO_Q     = (fifo_model.size() == 0) ? 8'h00 : fifo_model[0];
    endtask

    task automatic fifo_push(input logic [7:0] b);
        fifo_model.push_back(b);
        fifo_refresh();
    endtask

    // One CLK cycle: the FIFO model pops just after the edge when FIFO_READ
    // was high, then we settle on the next falling edge.
    task automatic step();
        logic popped;
        #1;
        popped = (FIFO_READ === 1'b1);
        @(posedge CLK);
        #1;
        if (popped) begin
            pop_count++;
            if (fifo_model.size() > 0) void'(fifo_model.pop_front());
            fifo_refresh();
        end
        @(negedge CLK);
    endtask

    task automatic wait_pop(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (FIFO_READ === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL pop_timeout: FIFO_READ never rose within 20 cycles");
        end
    endtask

    task automatic capture(input int n);
        for (int c = 1; c <= n; c++) begin
            step();
            sout_log[c] = SOUT;
            fin_log[c]  = TXFINISHED;
            busy_log[c] = BUSY;
            read_log[c] = FIFO_READ;
        end
    endtask

    task automatic set_cfg(input logic [1:0] wls, input logic stb, input logic pen,
                           input logic eps, input logic sp);
        WLS = wls;
        STB = stb;
        PEN = pen;
        EPS = eps;
        SP  = sp;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST = 1'b1;
        fifo_push(8'h11);
        step();
        step();
        tests_run++;
        if (SOUT !== 1'b1) begin tests_failed++; $display("FAIL reset_sout: got %b want 1", SOUT); end
        tests_run++;
        if (FIFO_READ !== 1'b0) begin tests_failed++; $display("FAIL reset_read: got %b want 0", FIFO_READ); end
        tests_run++;
        if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        tests_run++;
        if (TXFINISHED !== 1'b0) begin tests_failed++; $display("FAIL reset_fin: got %b want 0", TXFINISHED); end
        tests_run++;
        if (dbg_state !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        fifo_model.delete();
        fifo_refresh();
        RST = 1'b0;
        step();
    endtask

    task automatic test_basic_8n1();
        // slot i of the frame: start, 0xA5 LSB first, stop
        logic [9:0] exp_v;
        logic       ok;
        int         fin_cnt;
        exp_v = 10'b1101001010;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_count = 0;
        fifo_push(8'hA5);
        wait_pop(ok);
        if (!ok) return;
        capture(180);
        for (int c = 1; c <= 160; c++) begin
            tests_run++;
            if (sout_log[c] !== exp_v[(c - 1) / 16]) begin
                tests_failed++;
                $display("FAIL basic_sout c=%0d: got %b want %b", c, sout_log[c], exp_v[(c - 1) / 16]);
            end
        end
        fin_cnt = 0;
        for (int c = 1; c <= 180; c++) if (fin_log[c] === 1'b1) fin_cnt++;
        tests_run++;
        if (fin_log[161] !== 1'b1) begin tests_failed++; $display("FAIL basic_fin161: got %b want 1", fin_log[161]); end
        tests_run++;
        if (fin_cnt != 1) begin tests_failed++; $display("FAIL basic_fin_count: got %0d want 1", fin_cnt); end
        tests_run++;
        if (pop_count != 1) begin tests_failed++; $display("FAIL basic_pops: got %0d want 1", pop_count); end
        tests_run++;
        if (busy_log[160] !== 1'b1) begin tests_failed++; $display("FAIL basic_busy160: got %b want 1", busy_log[160]); end
        tests_run++;
        if (busy_log[161] !== 1'b0) begin tests_failed++; $display("FAIL basic_busy161: got %b want 0", busy_log[161]); end
    endtask

    task automatic test_short_word();
        // 0x13 as 5 bits: 1,1,0,0,1. Even parity of those is 1.
        logic [7:0] exp_v;
        int         nslots;
        int         frame_len;
        logic       ok;
`ifdef UART_TX_PARITY_EN
        exp_v     = 8'b0110_0110;
        nslots    = 7;
        frame_len = 136;
`else
        exp_v     = 8'b0010_0110;
        nslots    = 6;
        frame_len = 120;
`endif
        set_cfg(2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        fifo_push(8'h13);
        wait_pop(ok);
        if (!ok) return;
        capture(frame_len + 10);
        for (int c = 1; c <= nslots * 16; c++) begin
            tests_run++;
            if (sout_log[c] !== exp_v[(c - 1) / 16]) begin
                tests_failed++;
                $display("FAIL short_sout c=%0d: got %b want %b", c, sout_log[c], exp_v[(c - 1) / 16]);
            end
        end
        for (int c = nslots * 16 + 1; c <= frame_len; c++) begin
            tests_run++;
            if (sout_log[c] !== 1'b1) begin tests_failed++; $display("FAIL short_stop c=%0d: got %b want 1", c, sout_log[c]); end
        end
        tests_run++;
        if (fin_log[frame_len] !== 1'b0) begin tests_failed++; $display("FAIL short_fin_early: got %b want 0", fin_log[frame_len]); end
        tests_run++;
        if (fin_log[frame_len + 1] !== 1'b1) begin tests_failed++; $display("FAIL short_fin: got %b want 1", fin_log[frame_len + 1]); end
        tests_run++;
        if (busy_log[frame_len] !== 1'b1) begin tests_failed++; $display("FAIL short_busy: got %b want 1", busy_log[frame_len]); end
    endtask

    task automatic test_stick_parity();
        for (int e = 0; e < 2; e++) begin
            logic exp_par;
            int   fin_at;
            logic ok;
`ifdef UART_TX_PARITY_EN
            exp_par = (e == 0) ? 1'b1 : 1'b0;
            fin_at  = 177;
`else
            exp_par = 1'b1;
            fin_at  = 161;
`endif
            set_cfg(2'b11, 1'b0, 1'b1, (e == 1), 1'b1);
            fifo_push(8'h00);
            wait_pop(ok);
            if (!ok) return;
            capture(fin_at + 4);
            for (int s = 0; s <= 8; s++) begin
                tests_run++;
                if (sout_log[16 * s + 8] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stick_data e=%0d slot=%0d: got %b want 0", e, s, sout_log[16 * s + 8]);
                end
            end
            for (int c = 145; c <= 160; c++) begin
                tests_run++;
                if (sout_log[c] !== exp_par) begin
                    tests_failed++;
                    $display("FAIL stick_parity e=%0d c=%0d: got %b want %b", e, c, sout_log[c], exp_par);
                end
            end
            tests_run++;
            if (fin_log[fin_at] !== 1'b1) begin tests_failed++; $display("FAIL stick_fin e=%0d: got %b want 1", e, fin_log[fin_at]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1;
        logic [7:0] d2;
        logic       ok;
        int         reads;
        int         overlap;
        d1 = 8'h55;
        d2 = 8'hAA;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_count = 0;
        fifo_push(d1);
        fifo_push(d2);
        wait_pop(ok);
        if (!ok) return;
        capture(340);
        for (int s = 1; s <= 8; s++) begin
            tests_run++;
            if (sout_log[16 * s + 8] !== d1[s - 1]) begin
                tests_failed++;
                $display("FAIL b2b_d1 bit=%0d: got %b want %b", s - 1, sout_log[16 * s + 8], d1[s - 1]);
            end
            tests_run++;
            if (sout_log[161 + 16 * s + 8] !== d2[s - 1]) begin
                tests_failed++;
                $display("FAIL b2b_d2 bit=%0d: got %b want %b", s - 1, sout_log[161 + 16 * s + 8], d2[s - 1]);
            end
        end
        tests_run++;
        if (fin_log[161] !== 1'b1) begin tests_failed++; $display("FAIL b2b_fin1: got %b want 1", fin_log[161]); end
        tests_run++;
        if (read_log[161] !== 1'b1) begin tests_failed++; $display("FAIL b2b_pop2: got %b want 1", read_log[161]); end
        tests_run++;
        if (sout_log[161] !== 1'b1) begin tests_failed++; $display("FAIL b2b_gap: got %b want 1", sout_log[161]); end
        tests_run++;
        if (sout_log[162] !== 1'b0) begin tests_failed++; $display("FAIL b2b_start2: got %b want 0", sout_log[162]); end
        tests_run++;
        if (fin_log[322] !== 1'b1) begin tests_failed++; $display("FAIL b2b_fin2: got %b want 1", fin_log[322]); end
        reads   = 0;
        overlap = 0;
        for (int c = 1; c <= 340; c++) begin
            if (read_log[c] === 1'b1) reads++;
            if (read_log[c] === 1'b1 && busy_log[c] === 1'b1) overlap++;
        end
        tests_run++;
        if (reads != 1) begin tests_failed++; $display("FAIL b2b_reads_after_first: got %0d want 1", reads); end
        tests_run++;
        if (overlap != 0) begin tests_failed++; $display("FAIL b2b_read_while_busy: got %0d want 0", overlap); end
        tests_run++;
        if (pop_count != 2) begin tests_failed++; $display("FAIL b2b_pops: got %0d want 2", pop_count); end
        tests_run++;
        if (FIFO_EMPTY !== 1'b1) begin tests_failed++; $display("FAIL b2b_empty: got %b want 1", FIFO_EMPTY); end
    endtask

    task automatic test_clear();
        logic [7:0] d2;
        logic       ok;
        int         fin_cnt;
        d2 = 8'h33;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_count = 0;
        fifo_push(8'h07);
        fifo_push(d2);
        wait_pop(ok);
        if (!ok) return;
        for (int c = 1; c <= 70; c++) step();
        // cycle 70 is inside data bit 3 of 0x07, which is 0
        tests_run++;
        if (SOUT !== 1'b0) begin tests_failed++; $display("FAIL clear_pre_sout: got %b want 0", SOUT); end
        CLEAR = 1'b1;
        step();
        tests_run++;
        if (SOUT !== 1'b1) begin tests_failed++; $display("FAIL clear_sout: got %b want 1", SOUT); end
        tests_run++;
        if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL clear_busy: got %b want 0", BUSY); end
        tests_run++;
        if (TXFINISHED !== 1'b0) begin tests_failed++; $display("FAIL clear_fin: got %b want 0", TXFINISHED); end
        tests_run++;
        if (dbg_state !== 3'd0) begin tests_failed++; $display("FAIL clear_state: got %0d want 0", dbg_state); end
        tests_run++;
        if (FIFO_READ !== 1'b0) begin tests_failed++; $display("FAIL clear_no_pop: got %b want 0", FIFO_READ); end
        step();
        tests_run++;
        if (FIFO_READ !== 1'b0 || TXFINISHED !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_hold: got read=%b fin=%b want 0 0", FIFO_READ, TXFINISHED);
        end
        CLEAR = 1'b0;
        #1;
        tests_run++;
        if (FIFO_READ !== 1'b1) begin tests_failed++; $display("FAIL clear_repop: got %b want 1", FIFO_READ); end
        capture(170);
        for (int s = 1; s <= 8; s++) begin
            tests_run++;
            if (sout_log[16 * s + 8] !== d2[s - 1]) begin
                tests_failed++;
                $display("FAIL clear_d2 bit=%0d: got %b want %b", s - 1, sout_log[16 * s + 8], d2[s - 1]);
            end
        end
        fin_cnt = 0;
        for (int c = 1; c <= 170; c++) if (fin_log[c] === 1'b1) fin_cnt++;
        tests_run++;
        if (fin_log[161] !== 1'b1 || fin_cnt != 1) begin
            tests_failed++;
            $display("FAIL clear_fin2: got fin161=%b count=%0d want 1 1", fin_log[161], fin_cnt);
        end
        tests_run++;
        if (pop_count != 2) begin tests_failed++; $display("FAIL clear_pops: got %0d want 2", pop_count); end
    endtask

    task automatic test_break();
        logic ok;
        int   fin_cycle;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        fifo_push(8'hFF);
        wait_pop(ok);
        if (!ok) return;
        for (int c = 1; c <= 20; c++) step();
        BC = 1'b1;
        for (int c = 21; c <= 100; c++) begin
            step();
            tests_run++;
            if (SOUT !== 1'b0) begin tests_failed++; $display("FAIL break_sout c=%0d: got %b want 0", c, SOUT); end
        end
        tests_run++;
        if (BUSY !== 1'b1) begin tests_failed++; $display("FAIL break_busy: got %b want 1", BUSY); end
        BC = 1'b0;
        step();
        tests_run++;
        if (SOUT !== 1'b1) begin tests_failed++; $display("FAIL break_release: got %b want 1", SOUT); end
        fin_cycle = 0;
        for (int c = 102; c <= 170; c++) begin
            step();
            if (TXFINISHED === 1'b1 && fin_cycle == 0) fin_cycle = c;
        end
        tests_run++;
        if (fin_cycle != 161) begin tests_failed++; $display("FAIL break_fin_cycle: got %0d want 161", fin_cycle); end
        // break while idle
        BC = 1'b1;
        step();
        tests_run++;
        if (SOUT !== 1'b0) begin tests_failed++; $display("FAIL break_idle: got %b want 0", SOUT); end
        BC = 1'b0;
        step();
        tests_run++;
        if (SOUT !== 1'b1) begin tests_failed++; $display("FAIL break_idle_release: got %b want 1", SOUT); end
    endtask

    task automatic test_txclk_freeze();
        logic ok;
        int   fin_cycle;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        fifo_push(8'hA5);
        wait_pop(ok);
        if (!ok) return;
        for (int c = 1; c <= 29; c++) step();
        TXCLK = 1'b0;
        for (int c = 30; c <= 49; c++) begin
            step();
            tests_run++;
            if (SOUT !== 1'b1 || dbg_state !== 3'd2) begin
                tests_failed++;
                $display("FAIL freeze c=%0d: got sout=%b state=%0d want 1 2", c, SOUT, dbg_state);
            end
        end
        TXCLK = 1'b1;
        fin_cycle = 0;
        for (int c = 50; c <= 200; c++) begin
            step();
            if (TXFINISHED === 1'b1 && fin_cycle == 0) fin_cycle = c;
        end
        tests_run++;
        if (fin_cycle != 181) begin tests_failed++; $display("FAIL freeze_fin_cycle: got %0d want 181", fin_cycle); end
    endtask

    task automatic test_reset_midframe();
        logic ok;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        fifo_push(8'h00);
        fifo_push(8'h5A);
        wait_pop(ok);
        if (!ok) return;
        for (int c = 1; c <= 50; c++) step();
        BC  = 1'b1;
        RST = 1'b1;
        step();
        tests_run++;
        if (SOUT !== 1'b1) begin tests_failed++; $display("FAIL rst_sout: got %b want 1", SOUT); end
        tests_run++;
        if (BUSY !== 1'b0 || TXFINISHED !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_flags: got busy=%b fin=%b want 0 0", BUSY, TXFINISHED);
        end
        tests_run++;
        if (FIFO_READ !== 1'b0) begin tests_failed++; $display("FAIL rst_no_pop: got %b want 0", FIFO_READ); end
        tests_run++;
        if (dbg_state !== 3'd0) begin tests_failed++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        BC  = 1'b0;
        RST = 1'b0;
        #1;
        tests_run++;
        if (FIFO_READ !== 1'b1) begin tests_failed++; $display("FAIL rst_repop: got %b want 1", FIFO_READ); end
        capture(170);
        tests_run++;
        if (fin_log[161] !== 1'b1) begin tests_failed++; $display("FAIL rst_fin: got %b want 1", fin_log[161]); end
        tests_run++;
        if (sout_log[24] !== 1'b0 || sout_log[40] !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_data: got %b%b want 01", sout_log[24], sout_log[40]);
        end
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        pop_count    = 0;
        RST          = 1'b1;
        TXCLK        = 1'b1;
        CLEAR        = 1'b0;
        BC           = 1'b0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        fifo_refresh();
        @(negedge CLK);
        test_reset();
        test_basic_8n1();
        test_short_word();
        test_stick_parity();
        test_back_to_back();
        test_clear();
        test_break();
        test_txclk_freeze();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
